triangle_frame_buffer: RTL and testbench

Triple-buffered store for the projected triangles of one frame. Sits directly downstream of the full projector: captures every 128-bit triangle it emits, commits the set when the projector signals frame completion, and replays the latest committed frame to the rasterizer, one triangle per beat, on each frame-start request. Lets geometry generation and rasterization run at independent rates without backpressure on the projector, which has none.

---
 rtl/triangle_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_triangle_frame_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_frame_buffer.sv
// Triple-buffered frame store between the projector and the rasterizer: write bank W fills,
// a commit swaps W with the pending bank P, and a replay drains display bank D through a 2-entry skid.
module triangle_frame_buffer #(
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] triangle_in,
    input  logic         triangle_in_valid,
    input  logic         frame_done_in,
    input  logic         frame_start,
    output logic [127:0] tri_out,
    output logic         tri_out_valid,
    input  logic         tri_out_ready,
    output logic         tri_out_last,
    output logic         render_busy,
    output logic         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    logic [127:0]  mem [3][DEPTH];

    logic [1:0]    w_q, d_q, p_q, w_d, d_d, p_d;
    logic          pv_q, pv_d;
    logic [CW-1:0] count_q [3];
    logic [CW-1:0] count_d [3];
    logic          fd_prev_q;
    logic          overflow_q;

    state_t        state_q;
    logic [CW-1:0] raddr_q, rd_cnt_q;
    logic          busy_q;

    logic [1:0]    occ_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    last_q;
    logic [127:0]  skid_data_q [2];

    logic          commit, wr_ok, drop, start_ok, rd_en, rd_last, pop;
    logic [CW-1:0] wcnt, start_cnt;

    assign commit   = frame_done_in && !fd_prev_q;
    assign wcnt     = count_q[w_q];
    assign wr_ok    = triangle_in_valid && (wcnt < DEPTH_C);
    assign drop     = triangle_in_valid && !wr_ok;
    assign start_ok = frame_start && !busy_q;

    // Commit is resolved before frame_start so a same-cycle replay sees the just-committed bank.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_d       = w_q;
        d_d       = d_q;
        p_d       = p_q;
        pv_d      = pv_q;
        count_d   = count_q;
        if (wr_ok) count_d[w_q] = wcnt + CW'(1);
        if (commit) begin
            w_d           = p_q;
            p_d           = w_q;
            pv_d          = 1'b1;
            count_d[p_q]  = '0;
        end
        if (start_ok && pv_d) begin
            d_d  = p_d;
            p_d  = d_q;
            pv_d = 1'b0;
        end
        start_cnt = count_d[d_d];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q        <= 2'd0;
            d_q        <= 2'd1;
            p_q        <= 2'd2;
            pv_q       <= 1'b0;
            fd_prev_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 3; i++) count_q[i] <= '0;
        end else begin
            w_q        <= w_d;
            d_q        <= d_d;
            p_q        <= p_d;
            pv_q       <= pv_d;
            fd_prev_q  <= frame_done_in;
            count_q    <= count_d;
            overflow_q <= commit ? 1'b0 : (overflow_q || drop);
        end
    end

    // NOTE: the triangle store has no reset; its contents only matter below the committed count.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_q][wcnt[AW-1:0]] <= triangle_in;
    end

    // Reads stop when the skid is full, keeping tri_out_ready off the memory read path.
    assign rd_en   = (state_q == S_READ) && (occ_q != 2'd2);
    assign rd_last = (raddr_q == rd_cnt_q - CW'(1));
    assign pop     = tri_out_valid && tri_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            raddr_q  <= '0;
            rd_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok && (start_cnt != '0)) begin
                        state_q  <= S_READ;
                        raddr_q  <= '0;
                        rd_cnt_q <= start_cnt;
                        busy_q   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        raddr_q <= raddr_q + CW'(1);
                        if (rd_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && tri_out_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            last_q   <= 2'b00;
        end else begin
            if (rd_en) begin
                last_q[wr_ptr_q] <= rd_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, rd_en} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) skid_data_q[wr_ptr_q] <= mem[d_q][raddr_q[AW-1:0]];
    end

    assign tri_out       = skid_data_q[rd_ptr_q];
    assign tri_out_valid = (occ_q != 2'd0);
    assign tri_out_last  = tri_out_valid && last_q[rd_ptr_q];
    assign render_busy   = busy_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_triangle_frame_buffer.sv
// Self-checking bench for triangle_frame_buffer: a scoreboard queue holds the expected replay beats,
// a table drives whole frames, and hand sequences cover timing, commit ordering and async reset.
module tb_triangle_frame_buffer;

    localparam int DEPTH  = 256;
    localparam int BUDGET = DEPTH * 4 + 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] triangle_in = '0;
    logic         triangle_in_valid = 1'b0;
    logic         frame_done_in = 1'b0;
    logic         frame_start = 1'b0;
    logic [127:0] tri_out;
    logic         tri_out_valid;
    logic         tri_out_ready = 1'b1;
    logic         tri_out_last;
    logic         render_busy;
    logic         overflow;

    triangle_frame_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .triangle_in       (triangle_in),
        .triangle_in_valid (triangle_in_valid),
        .frame_done_in     (frame_done_in),
        .frame_start       (frame_start),
        .tri_out           (tri_out),
        .tri_out_valid     (tri_out_valid),
        .tri_out_ready     (tri_out_ready),
        .tri_out_last      (tri_out_last),
        .render_busy       (render_busy),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        int           n_write;
        logic [127:0] base;
        int           rdy_mode;
        int           exp_beats;
        logic         exp_ovf;
    } vec_t;

    beat_t sb [$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    beat_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every handshake pops the scoreboard; a stalled beat must hold its payload.
    logic         prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [127:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("stall_valid", tri_out_valid, 1'b1);
                check("stall_data", tri_out, prev_d);
                check("stall_last", tri_out_last, prev_l);
            end
            if (tri_out_valid && tri_out_ready) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", tri_out, 128'hDEAD);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_data", tri_out, e.data);
                    check("beat_last", tri_out_last, e.last);
                end
            end
            prev_v = tri_out_valid;
            prev_r = tri_out_ready;
            prev_d = tri_out;
            prev_l = tri_out_last;
        end
    end

    task automatic write_tris(input int n, input logic [127:0] base);
        for (int i = 0; i < n; i++) begin
            triangle_in_valid = 1'b1;
            triangle_in       = base + 128'(i);
            @(posedge clk); #1;
        end
        triangle_in_valid = 1'b0;
    endtask

    task automatic commit_frame();
        frame_done_in = 1'b1;
        @(posedge clk); #1;
        frame_done_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_frame(input logic [127:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 128'(i);
            b.last = (i == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int mode);
        int c = 0;
        while ((render_busy || sb.size() != 0) && c < BUDGET) begin
            case (mode)
                1:       tri_out_ready = c[0];
                2:       tri_out_ready = 1'($urandom_range(0, 1));
                default: tri_out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            c++;
        end
        tri_out_ready = 1'b1;
        check("replay_timeout", (c >= BUDGET), 1'b0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{n_write: 5,         base: 128'h1111_0000, rdy_mode: 1, exp_beats: 5,     exp_ovf: 1'b0};
        vecs[1] = '{n_write: DEPTH + 3, base: 128'h2222_0000, rdy_mode: 0, exp_beats: DEPTH, exp_ovf: 1'b1};
        vecs[2] = '{n_write: 1,         base: 128'h3333_0000, rdy_mode: 2, exp_beats: 1,     exp_ovf: 1'b0};
        vecs[3] = '{n_write: 7,         base: 128'h4444_0000, rdy_mode: 2, exp_beats: 7,     exp_ovf: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tri_out_valid, 1'b0);
        check("rst_busy", render_busy, 1'b0);
        check("rst_last", tri_out_last, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // A, B, C with exact cycle timing relative to frame_start.
        write_tris(3, 128'hA);
        commit_frame();
        push_frame(128'hA, 3);
        beat_cnt    = 0;
        frame_start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("abc_busy_c%0d", k), render_busy, (k >= 1 && k <= 4));
            check($sformatf("abc_valid_c%0d", k), tri_out_valid, (k >= 2 && k <= 4));
            check($sformatf("abc_last_c%0d", k), tri_out_last, (k == 4));
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        check("abc_beats", beat_cnt, 3);

        // Replay again with no new commit.
        push_frame(128'hA, 3);
        beat_cnt = 0;
        pulse_start();
        wait_idle(0);
        check("abc_again_beats", beat_cnt, 3);

        // Table-driven frames: write, commit, replay under a ready pattern.
        for (int v = 0; v < 4; v++) begin
            write_tris(vecs[v].n_write, vecs[v].base);
            check($sformatf("vec%0d_ovf_pre", v), overflow, vecs[v].exp_ovf);
            commit_frame();
            check($sformatf("vec%0d_ovf_post", v), overflow, 1'b0);
            push_frame(vecs[v].base, vecs[v].exp_beats);
            beat_cnt = 0;
            pulse_start();
            wait_idle(vecs[v].rdy_mode);
            check($sformatf("vec%0d_beats", v), beat_cnt, vecs[v].exp_beats);
        end

        // Two commits before a replay: the newer frame wins.
        write_tris(3, 128'h5800);
        commit_frame();
        write_tris(2, 128'h5900);
        commit_frame();
        push_frame(128'h5900, 2);
        beat_cnt = 0;
        pulse_start();
        wait_idle(0);
        check("xy_beats", beat_cnt, 2);

        // Held-high frame_done_in commits once; a second rise is needed for the next frame.
        write_tris(2, 128'h6100);
        frame_done_in = 1'b1;
        @(posedge clk); #1;
        write_tris(3, 128'h6200);
        push_frame(128'h6100, 2);
        beat_cnt = 0;
        pulse_start();
        wait_idle(0);
        check("held_first_beats", beat_cnt, 2);
        frame_done_in = 1'b0;
        @(posedge clk); #1;
        commit_frame();
        push_frame(128'h6200, 3);
        beat_cnt = 0;
        pulse_start();
        wait_idle(0);
        check("held_second_beats", beat_cnt, 3);

        // Commit, final triangle and frame_start all in one cycle.
        write_tris(2, 128'h7A00);
        push_frame(128'h7A00, 3);
        beat_cnt          = 0;
        triangle_in       = 128'h7A02;
        triangle_in_valid = 1'b1;
        frame_done_in     = 1'b1;
        frame_start       = 1'b1;
        @(posedge clk); #1;
        triangle_in_valid = 1'b0;
        frame_done_in     = 1'b0;
        frame_start       = 1'b0;
        wait_idle(2);
        check("z_beats", beat_cnt, 3);

        // Async reset in the middle of a stalled replay with overflow set.
        write_tris(4, 128'h8800);
        commit_frame();
        push_frame(128'h8800, 4);
        tri_out_ready = 1'b0;
        pulse_start();
        write_tris(DEPTH + 1, 128'h9900);
        check("mid_busy", render_busy, 1'b1);
        check("mid_valid", tri_out_valid, 1'b1);
        check("mid_overflow", overflow, 1'b1);
        rst = 1'b0;
        #2;
        check("arst_valid", tri_out_valid, 1'b0);
        check("arst_busy", render_busy, 1'b0);
        check("arst_last", tri_out_last, 1'b0);
        check("arst_overflow", overflow, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        rst           = 1'b1;
        tri_out_ready = 1'b1;
        @(posedge clk); #1;
        beat_cnt = 0;
        pulse_start();
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                seen = seen | tri_out_valid | render_busy;
            end
            check("post_rst_idle", seen, 1'b0);
        end
        check("post_rst_beats", beat_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
